shared_timer_arbiter: RTL and testbench

- Controller that shares one interval counter among NUM_REQ requesters.
- Arbitrates round-robin, loads the winner's period and sequences the count.
- Reports completion or abort to the winner, then releases the counter.
- Used wherever several blocks need bit-period or wait timing but only one counter is budgeted.

---
 rtl/shared_timer_arbiter_if.sv | 23 ++
 rtl/shared_timer_arbiter.sv | 149 ++++++++++++++
 tb/tb_shared_timer_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_timer_arbiter_if.sv
// Handshake bundle between the requesters (master) and the shared interval timer (slave).
interface shared_timer_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CNT_BITS = 8
);
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*NUM_CNT_BITS-1:0] period;
    logic [NUM_REQ-1:0]              grant;
    logic                            busy;
    logic [NUM_CNT_BITS-1:0]         count_out;
    logic [NUM_REQ-1:0]              done;
    logic [NUM_REQ-1:0]              abort;

    modport master (
        output req, period,
        input  grant, busy, count_out, done, abort
    );

    modport slave (
        input  req, period,
        output grant, busy, count_out, done, abort
    );
endinterface

// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among NUM_REQ requesters.
// Optional macro SHARED_TIMER_B2B_EN: DONE hands the counter straight to the next winner.
module shared_timer_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_timer_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  r_state,  w_stateNext;
    logic [NUM_REQ-1:0]      r_grant,  w_grantNext;
    logic [NUM_REQ-1:0]      r_done,   w_doneNext;
    logic [NUM_REQ-1:0]      r_abort,  w_abortNext;
    logic [IDX_W-1:0]        r_owner,  w_ownerNext;
    logic [IDX_W-1:0]        r_last,   w_lastNext;
    logic [NUM_CNT_BITS-1:0] r_count,  w_countNext;
    logic [NUM_CNT_BITS-1:0] r_period, w_periodNext;

    logic [IDX_W-1:0]        w_arbBase;
    logic [IDX_W-1:0]        w_arbIdx;
    logic [IDX_W-1:0]        w_scanIdx;
    logic                    w_arbValid;
    logic [NUM_REQ-1:0]      w_arbGrant;
    logic [NUM_CNT_BITS-1:0] w_periodSel;
    logic [NUM_CNT_BITS-1:0] w_loadPeriod;
    logic [NUM_CNT_BITS-1:0] w_countInc;
    logic                    w_ownerReq;

    // In DONE the owner just finished, so it becomes the lowest priority for the handoff.
    assign w_arbBase = (r_state == ST_DONE) ? r_owner : r_last;

    always_comb begin
        w_arbIdx   = '0;
        w_arbValid = 1'b0;
        w_scanIdx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scanIdx = IDX_W'((int'(w_arbBase) + k) % NUM_REQ);
            if (!w_arbValid && bus.req[w_scanIdx]) begin
                w_arbValid = 1'b1;
                w_arbIdx   = w_scanIdx;
            end
        end
    end

    assign w_arbGrant   = w_arbValid ? (NUM_REQ'(1) << w_arbIdx) : '0;
    assign w_periodSel  = NUM_CNT_BITS'(bus.period >> (int'(r_owner) * NUM_CNT_BITS));
    assign w_loadPeriod = (w_periodSel == '0) ? NUM_CNT_BITS'(1) : w_periodSel;
    assign w_countInc   = r_count + NUM_CNT_BITS'(1);
    assign w_ownerReq   = bus.req[r_owner];

    always_comb begin
        w_stateNext  = r_state;
        w_grantNext  = r_grant;
        w_ownerNext  = r_owner;
        w_lastNext   = r_last;
        w_countNext  = r_count;
        w_periodNext = r_period;
        w_doneNext   = '0;
        w_abortNext  = '0;

        case (r_state)
            ST_IDLE: begin
                w_countNext = '0;
                if (w_arbValid) begin
                    w_grantNext = w_arbGrant;
                    w_ownerNext = w_arbIdx;
                    w_stateNext = ST_LOAD;
                end
            end

            ST_LOAD, ST_RUN: begin
                // Owner withdrew before completion: pulse abort from the IDLE cycle that follows.
                if (!w_ownerReq) begin
                    w_abortNext = r_grant;
                    w_grantNext = '0;
                    w_countNext = '0;
                    w_lastNext  = r_owner;
                    w_stateNext = ST_IDLE;
                end else if (r_state == ST_LOAD) begin
                    w_periodNext = w_loadPeriod;
                    w_countNext  = '0;
                    w_stateNext  = ST_RUN;
                end else begin
                    w_countNext = w_countInc;
                    if (w_countInc == r_period) begin
                        w_doneNext  = r_grant;
                        w_stateNext = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                w_lastNext  = r_owner;
                w_grantNext = '0;
                w_countNext = '0;
                w_stateNext = ST_IDLE;
`ifdef SHARED_TIMER_B2B_EN
                if (w_arbValid) begin
                    w_grantNext = w_arbGrant;
                    w_ownerNext = w_arbIdx;
                    w_stateNext = ST_LOAD;
                end
`endif
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_abort  <= '0;
            r_owner  <= '0;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_count  <= '0;
            r_period <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_grant  <= w_grantNext;
            r_done   <= w_doneNext;
            r_abort  <= w_abortNext;
            r_owner  <= w_ownerNext;
            r_last   <= w_lastNext;
            r_count  <= w_countNext;
            r_period <= w_periodNext;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.count_out = r_count;
    assign bus.done      = r_done;
    assign bus.abort     = r_abort;
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Testbench for shared_timer_arbiter: directed scenarios then random traffic against a timestamp model.
module tb_shared_timer_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int NUM_CNT_BITS = 8;
    localparam int PW           = NUM_REQ * NUM_CNT_BITS;
`ifdef SHARED_TIMER_B2B_EN
    localparam int HANDOFF_GAP = 4;
`else
    localparam int HANDOFF_GAP = 5;
`endif

    logic clk = 1'b0;
    logic rst;

    shared_timer_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_CNT_BITS(NUM_CNT_BITS)) bus ();

    shared_timer_arbiter #(.NUM_REQ(NUM_REQ), .NUM_CNT_BITS(NUM_CNT_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int cycleNum  = 0;

    // Reference model: owner index, edges since its grant, and its effective period.
    int mOwner = -1;
    int mLast  = NUM_REQ - 1;
    int mAge   = 0;
    int mP     = 1;

    logic [NUM_REQ-1:0]      eGrant = '0;
    logic [NUM_REQ-1:0]      eDone  = '0;
    logic [NUM_REQ-1:0]      eAbort = '0;
    logic                    eBusy  = 1'b0;
    logic [NUM_CNT_BITS-1:0] eCount = '0;

    int                 logIdx[$];
    int                 logCyc[$];
    logic [NUM_REQ-1:0] prevGrant = '0;

    logic [NUM_REQ-1:0] rReq;
    logic [PW-1:0]      rPer;
    logic               rRst;
    logic [NUM_REQ-1:0] bitM;
    logic [PW-1:0]      slotMask;
    int                 expOrder[5];

    function automatic logic [PW-1:0] mkPer(input logic [7:0] p0, input logic [7:0] p1,
                                            input logic [7:0] p2, input logic [7:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic int oneHotIdx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (v == (NUM_REQ'(1) << i)) r = i;
        return r;
    endfunction

    task automatic modelStep(input logic rstV, input logic [NUM_REQ-1:0] reqV, input logic [PW-1:0] perV);
        logic arbNow;
        int   pSel;
        int   cand;
        arbNow = 1'b0;
        eDone  = '0;
        eAbort = '0;
        if (rstV) begin
            mOwner = -1;
            mLast  = NUM_REQ - 1;
            eGrant = '0;
            eBusy  = 1'b0;
            eCount = '0;
        end else if (mOwner < 0) begin
            arbNow = 1'b1;
        end else begin
            mAge++;
            if (mAge == 1) begin
                pSel = int'(NUM_CNT_BITS'(perV >> (mOwner * NUM_CNT_BITS)));
                mP   = (pSel == 0) ? 1 : pSel;
            end
            if (mAge <= mP + 1 && ((reqV >> mOwner) & NUM_REQ'(1)) == '0) begin
                eAbort = NUM_REQ'(1) << mOwner;
                mLast  = mOwner;
                mOwner = -1;
                eGrant = '0;
                eBusy  = 1'b0;
                eCount = '0;
            end else if (mAge <= mP + 1) begin
                eCount = NUM_CNT_BITS'(mAge - 1);
                if (mAge == mP + 1) eDone = NUM_REQ'(1) << mOwner;
            end else begin
                mLast  = mOwner;
                mOwner = -1;
                eGrant = '0;
                eBusy  = 1'b0;
                eCount = '0;
`ifdef SHARED_TIMER_B2B_EN
                arbNow = 1'b1;
`endif
            end
        end
        if (arbNow && reqV != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = (mLast + k) % NUM_REQ;
                if (mOwner < 0 && ((reqV >> cand) & NUM_REQ'(1)) != '0) mOwner = cand;
            end
            mAge   = 0;
            eGrant = NUM_REQ'(1) << mOwner;
            eBusy  = 1'b1;
            eCount = '0;
        end
    endtask

    task automatic checkOutput();
        testCount++;
        assert (bus.grant === eGrant) else begin
            failCount++;
            $error("[TB] FAIL grant cycle=%0d observed=%b expected=%b", cycleNum, bus.grant, eGrant);
        end
        testCount++;
        assert (bus.busy === eBusy) else begin
            failCount++;
            $error("[TB] FAIL busy cycle=%0d observed=%b expected=%b", cycleNum, bus.busy, eBusy);
        end
        testCount++;
        assert (bus.count_out === eCount) else begin
            failCount++;
            $error("[TB] FAIL count cycle=%0d observed=%0d expected=%0d", cycleNum, bus.count_out, eCount);
        end
        testCount++;
        assert (bus.done === eDone) else begin
            failCount++;
            $error("[TB] FAIL done cycle=%0d observed=%b expected=%b", cycleNum, bus.done, eDone);
        end
        testCount++;
        assert (bus.abort === eAbort) else begin
            failCount++;
            $error("[TB] FAIL abort cycle=%0d observed=%b expected=%b", cycleNum, bus.abort, eAbort);
        end
    endtask

    task automatic logGrant();
        if (bus.grant !== '0 && bus.grant !== prevGrant) begin
            logIdx.push_back(oneHotIdx(bus.grant));
            logCyc.push_back(cycleNum);
        end
        prevGrant = bus.grant;
    endtask

    task automatic applyStimulus(input logic rstV, input logic [NUM_REQ-1:0] reqV, input logic [PW-1:0] perV);
        rst        = rstV;
        bus.req    = reqV;
        bus.period = perV;
        @(posedge clk);
        cycleNum++;
        modelStep(rstV, reqV, perV);
        #1;
        checkOutput();
        logGrant();
    endtask

    initial begin
        slotMask = PW'({NUM_CNT_BITS{1'b1}});
        expOrder = '{0, 1, 2, 3, 0};

        // Reset, then an idle bus must stay quiet.
        repeat (2) applyStimulus(1'b1, '0, '0);
        repeat (10) applyStimulus(1'b0, '0, '0);

        // Single request, period 3; requester drops req during the DONE cycle.
        repeat (5) applyStimulus(1'b0, 4'b0001, mkPer(8'd3, 8'd0, 8'd0, 8'd0));
        repeat (4) applyStimulus(1'b0, 4'b0000, mkPer(8'd3, 8'd0, 8'd0, 8'd0));

        // Round-robin with all requesters held.
        applyStimulus(1'b1, '0, '0);
        logIdx.delete();
        logCyc.delete();
        repeat (30) applyStimulus(1'b0, 4'b1111, mkPer(8'd2, 8'd2, 8'd2, 8'd2));
        repeat (8) applyStimulus(1'b0, 4'b0000, mkPer(8'd2, 8'd2, 8'd2, 8'd2));
        testCount++;
        assert (logIdx.size() >= 5) else begin
            failCount++;
            $error("[TB] FAIL rrGrants observed=%0d expected>=5", logIdx.size());
        end
        for (int i = 0; i < 5 && i < logIdx.size(); i++) begin
            testCount++;
            assert (logIdx[i] === expOrder[i]) else begin
                failCount++;
                $error("[TB] FAIL rrOrder[%0d] observed=%0d expected=%0d", i, logIdx[i], expOrder[i]);
            end
        end
        for (int i = 1; i < 5 && i < logCyc.size(); i++) begin
            testCount++;
            assert ((logCyc[i] - logCyc[i-1]) === HANDOFF_GAP) else begin
                failCount++;
                $error("[TB] FAIL rrGap[%0d] observed=%0d expected=%0d", i, logCyc[i] - logCyc[i-1], HANDOFF_GAP);
            end
        end

        // Abort: requester 1 drops req after its 4th RUN cycle while requester 2 waits.
        applyStimulus(1'b1, '0, '0);
        logIdx.delete();
        logCyc.delete();
        applyStimulus(1'b0, 4'b0010, mkPer(8'd5, 8'd10, 8'd5, 8'd5));
        repeat (4) applyStimulus(1'b0, 4'b0110, mkPer(8'd5, 8'd10, 8'd5, 8'd5));
        repeat (8) applyStimulus(1'b0, 4'b0100, mkPer(8'd5, 8'd10, 8'd5, 8'd5));
        repeat (4) applyStimulus(1'b0, 4'b0000, mkPer(8'd5, 8'd10, 8'd5, 8'd5));
        testCount++;
        assert (logIdx.size() >= 2) else begin
            failCount++;
            $error("[TB] FAIL abortGrants observed=%0d expected>=2", logIdx.size());
        end
        if (logIdx.size() >= 2) begin
            testCount++;
            assert (logIdx[0] === 1 && logIdx[1] === 2) else begin
                failCount++;
                $error("[TB] FAIL abortOrder observed=%0d,%0d expected=1,2", logIdx[0], logIdx[1]);
            end
            testCount++;
            assert ((logCyc[1] - logCyc[0]) === 6) else begin
                failCount++;
                $error("[TB] FAIL abortGap observed=%0d expected=6", logCyc[1] - logCyc[0]);
            end
        end

        // Period 0 behaves as period 1.
        applyStimulus(1'b1, '0, '0);
        repeat (3) applyStimulus(1'b0, 4'b0001, mkPer(8'd0, 8'd0, 8'd0, 8'd0));
        repeat (3) applyStimulus(1'b0, 4'b0000, mkPer(8'd0, 8'd0, 8'd0, 8'd0));

        // Maximum period counts to 255 without wrapping.
        repeat (257) applyStimulus(1'b0, 4'b0001, mkPer(8'hFF, 8'd0, 8'd0, 8'd0));
        repeat (3) applyStimulus(1'b0, 4'b0000, mkPer(8'hFF, 8'd0, 8'd0, 8'd0));

        // Reset at count 5, request held throughout and re-granted.
        repeat (7) applyStimulus(1'b0, 4'b0001, mkPer(8'd20, 8'd0, 8'd0, 8'd0));
        applyStimulus(1'b1, 4'b0001, mkPer(8'd20, 8'd0, 8'd0, 8'd0));
        repeat (22) applyStimulus(1'b0, 4'b0001, mkPer(8'd20, 8'd0, 8'd0, 8'd0));
        repeat (3) applyStimulus(1'b0, 4'b0000, mkPer(8'd20, 8'd0, 8'd0, 8'd0));

        // Random traffic: requesters raise at will, owners occasionally quit early.
        rReq = '0;
        rPer = mkPer(8'd3, 8'd1, 8'd4, 8'd2);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bitM = NUM_REQ'(1) << i;
                if (((eDone | eAbort) & bitM) != '0) begin
                    if ($urandom_range(1, 0) == 1) rReq = rReq & ~bitM;
                end else if ((rReq & bitM) == '0) begin
                    if ($urandom_range(3, 0) == 0) rReq = rReq | bitM;
                end else if (mOwner == i && $urandom_range(59, 0) == 0) begin
                    rReq = rReq & ~bitM;
                end
            end
            if ($urandom_range(7, 0) == 0) begin
                int j;
                j = int'($urandom_range(NUM_REQ - 1, 0));
                rPer = (rPer & ~(slotMask << (j * NUM_CNT_BITS)))
                     | (PW'($urandom_range(9, 0)) << (j * NUM_CNT_BITS));
            end
            rRst = ($urandom_range(499, 0) == 0);
            applyStimulus(rRst, rReq, rPer);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
